// File: rtl/irb_pkg.sv
// irb_pkg: shared types and buffer depths for the inverted residual block
package irb_pkg;
  typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_e;
  localparam int FMI_N_ELEM = 1024;
  localparam int KEX_N_ELEM = 288;
  localparam int KPW_N_ELEM = 512;
  localparam int KDW_N_ELEM = 144;
endpackage

// File: rtl/irb_pingpong_buffer_if.sv
// irb_pingpong_buffer_if: producer (DMA) and consumer (compute) handshake bundle
interface irb_pingpong_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              p_write;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic              p_done;
  logic              p_ready;
  logic              p_bank;
  logic              c_read;
  logic [ADDR_W-1:0] c_addr;
  logic              c_release;
  logic              c_valid;
  logic              c_bank;
  logic [CNT_W-1:0]  c_len;
  logic [DATA_W-1:0] c_res;
  logic              err;
  modport master (
    output p_write, p_addr, p_data, p_done, c_read, c_addr, c_release,
    input  p_ready, p_bank, c_valid, c_bank, c_len, c_res, err
  );
  modport slave (
    input  p_write, p_addr, p_data, p_done, c_read, c_addr, c_release,
    output p_ready, p_bank, c_valid, c_bank, c_len, c_res, err
  );
endinterface

// File: rtl/irb_bank_ram.sv
// irb_bank_ram: 1W/1R synchronous RAM bank with registered, holding read port
module irb_bank_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  // storage write, contents survive reset
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  // read register clears on reset and holds between reads
  always_ff @(posedge clk) begin
    if (rst) rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/irb_pingpong_buffer.sv
// irb_pingpong_buffer: double-banked tile buffer with done/release bank handoff
module irb_pingpong_buffer
  import irb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = FMI_N_ELEM,
  parameter int PINGPONG = 1,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  irb_pingpong_buffer_if.slave bus
);
  localparam int NB = (PINGPONG != 0) ? 2 : 1;
  bank_state_e       state_q [2];
  bank_state_e       state_d [2];
  logic [CNT_W-1:0]  len_q [2];
  logic [CNT_W-1:0]  len_d [2];
  logic [DATA_W-1:0] rdata [2];
  logic p_sel_q, p_sel_d, c_sel_q, c_sel_d, err_q, err_d, rd_bank_q;
  logic p_ready, c_valid, addr_ok, wr_ok, rd_ok, done_ok, rel_ok;
  assign p_ready = state_q[p_sel_q] == BANK_EMPTY;
  assign c_valid = state_q[c_sel_q] == BANK_FULL;
  assign wr_ok   = bus.p_write && p_ready && addr_ok;
  assign rd_ok   = bus.c_read && c_valid;
  assign done_ok = bus.p_done && p_ready;
  assign rel_ok  = bus.c_release && c_valid;
  if ((1 << ADDR_W) == DEPTH) begin : g_pow2
    assign addr_ok = 1'b1;
  end else begin : g_npow2
    assign addr_ok = bus.p_addr < ADDR_W'(DEPTH);
  end
  // bank ownership, fill counts and sticky protocol error
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    p_sel_d = p_sel_q;
    c_sel_d = c_sel_q;
    err_d   = err_q | (bus.p_write && !(p_ready && addr_ok)) | (bus.p_done && !p_ready)
                    | (bus.c_read && !c_valid) | (bus.c_release && !c_valid);
    if (wr_ok && len_q[p_sel_q] != CNT_W'(DEPTH)) len_d[p_sel_q] = len_q[p_sel_q] + 1'b1;
    if (done_ok) begin
      state_d[p_sel_q] = BANK_FULL;
      p_sel_d = (PINGPONG != 0) ? ~p_sel_q : p_sel_q;
    end
    if (rel_ok) begin
      state_d[c_sel_q] = BANK_EMPTY;
      len_d[c_sel_q] = '0;
      c_sel_d = (PINGPONG != 0) ? ~c_sel_q : c_sel_q;
    end
  end
  // handshake state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= '{default: BANK_EMPTY};
      len_q     <= '{default: '0};
      p_sel_q   <= 1'b0;
      c_sel_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      p_sel_q   <= p_sel_d;
      c_sel_q   <= c_sel_d;
      err_q     <= err_d;
      rd_bank_q <= rd_ok ? c_sel_q : rd_bank_q;
    end
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NB) begin : g_ram
      irb_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we_i   (wr_ok && p_sel_q == 1'(b)),
        .waddr_i(bus.p_addr),
        .wdata_i(bus.p_data),
        .re_i   (rd_ok && c_sel_q == 1'(b)),
        .raddr_i(bus.c_addr),
        .rdata_o(rdata[b])
      );
    end else begin : g_none
      assign rdata[b] = '0;
    end
  end
  assign bus.p_ready = p_ready;
  assign bus.p_bank  = p_sel_q;
  assign bus.c_valid = c_valid;
  assign bus.c_bank  = c_sel_q;
  assign bus.c_len   = c_valid ? len_q[c_sel_q] : '0;
  assign bus.c_res   = rdata[rd_bank_q];
  assign bus.err     = err_q;
endmodule

// File: tb/tb_irb_pingpong_buffer.sv
// tb_irb_pingpong_buffer: ping-pong (DEPTH 16) and single-bank (DEPTH 12) buffers driven in lockstep against a reference model
module tb_irb_pingpong_buffer;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  irb_pingpong_buffer_if #(.DATA_W(16), .DEPTH(16)) ifa ();
  irb_pingpong_buffer_if #(.DATA_W(16), .DEPTH(12)) ifb ();
  irb_pingpong_buffer #(.DATA_W(16), .DEPTH(16), .PINGPONG(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  irb_pingpong_buffer #(.DATA_W(16), .DEPTH(12), .PINGPONG(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    int d;
    bit pr, cv, pb, cb, er, rk;
    int len;
    logic [15:0] res;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  int depth[2] = '{16, 12};
  bit pp[2] = '{1'b1, 1'b0};
  bit full[2][2];
  int len[2][2];
  int ps[2];
  int cs[2];
  logic [15:0] mem[2][2][16];
  bit wrn[2][2][16];
  logic [15:0] res[2];
  bit rk[2];
  bit er[2];

  task automatic model(input int d, input bit r, w, input int wa, input logic [15:0] wd,
                       input bit dn, rd, input int ra, input bit rl);
    bit pr, cv;
    int p, c;
    exp_t e;
    if (r) begin
      full[d][0] = 0; full[d][1] = 0; len[d][0] = 0; len[d][1] = 0;
      ps[d] = 0; cs[d] = 0; res[d] = 0; rk[d] = 1; er[d] = 0;
    end else begin
      p = ps[d]; c = cs[d]; pr = !full[d][p]; cv = full[d][c];
      if (w) begin
        if (pr && wa < depth[d]) begin
          mem[d][p][wa] = wd; wrn[d][p][wa] = 1;
          if (len[d][p] < depth[d]) len[d][p] = len[d][p] + 1;
        end else er[d] = 1;
      end
      if (rd) begin
        if (cv) begin res[d] = mem[d][c][ra]; rk[d] = ra < depth[d] && wrn[d][c][ra]; end
        else er[d] = 1;
      end
      if (dn) begin
        if (pr) begin full[d][p] = 1; if (pp[d]) ps[d] = 1 - p; end
        else er[d] = 1;
      end
      if (rl) begin
        if (cv) begin full[d][c] = 0; len[d][c] = 0; if (pp[d]) cs[d] = 1 - c; end
        else er[d] = 1;
      end
    end
    e.d = d; e.pr = !full[d][ps[d]]; e.cv = full[d][cs[d]];
    e.pb = ps[d] == 1; e.cb = cs[d] == 1;
    e.len = e.cv ? len[d][cs[d]] : 0;
    e.res = res[d]; e.rk = rk[d]; e.er = er[d];
    sb.push_back(e);
  endtask

  task automatic step(input bit r, w, input int wa, input int wd, input bit dn, rd,
                      input int ra, input bit rl);
    @(negedge clk);
    #1;
    rst = r;
    ifa.p_write = w; ifa.p_addr = 4'(wa); ifa.p_data = 16'(wd); ifa.p_done = dn;
    ifa.c_read = rd; ifa.c_addr = 4'(ra); ifa.c_release = rl;
    ifb.p_write = w; ifb.p_addr = 4'(wa); ifb.p_data = 16'(wd); ifb.p_done = dn;
    ifb.c_read = rd; ifb.c_addr = 4'(ra); ifb.c_release = rl;
    model(0, r, w, wa, 16'(wd), dn, rd, ra, rl);
    model(1, r, w, wa, 16'(wd), dn, rd, ra, rl);
  endtask

  function automatic exp_t sample(input int d);
    exp_t g;
    g.d = d; g.rk = 1;
    if (d == 0) begin
      g.pr = ifa.p_ready; g.cv = ifa.c_valid; g.pb = ifa.p_bank; g.cb = ifa.c_bank;
      g.er = ifa.err; g.len = int'(ifa.c_len); g.res = ifa.c_res;
    end else begin
      g.pr = ifb.p_ready; g.cv = ifb.c_valid; g.pb = ifb.p_bank; g.cb = ifb.c_bank;
      g.er = ifb.err; g.len = int'(ifb.c_len); g.res = ifb.c_res;
    end
    return g;
  endfunction

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, want, $time);
    end
  endtask

  // scoreboard monitor: every posted expectation is compared on the falling edge after its clock
  always @(negedge clk) begin
    exp_t e, g;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      g = sample(e.d);
      check($sformatf("dut%0d p_ready", e.d), 32'(g.pr), 32'(e.pr));
      check($sformatf("dut%0d c_valid", e.d), 32'(g.cv), 32'(e.cv));
      check($sformatf("dut%0d p_bank", e.d), 32'(g.pb), 32'(e.pb));
      check($sformatf("dut%0d c_bank", e.d), 32'(g.cb), 32'(e.cb));
      check($sformatf("dut%0d c_len", e.d), 32'(g.len), 32'(e.len));
      check($sformatf("dut%0d err", e.d), 32'(g.er), 32'(e.er));
      if (e.rk) check($sformatf("dut%0d c_res", e.d), 32'(g.res), 32'(e.res));
    end
  end

  initial begin
    ifa.p_write = 0; ifa.p_addr = 0; ifa.p_data = 0; ifa.p_done = 0;
    ifa.c_read = 0; ifa.c_addr = 0; ifa.c_release = 0;
    ifb.p_write = 0; ifb.p_addr = 0; ifb.p_data = 0; ifb.p_done = 0;
    ifb.c_read = 0; ifb.c_addr = 0; ifb.c_release = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // first tile into bank 0, hand over, read back
    for (int i = 0; i < 4; i++) step(0, 1, i, 'hA0 + i, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // fill bank 1 while bank 0 is being read, then hand over both
    for (int i = 0; i < 8; i++) step(0, 1, i, 'hB0 + i, 0, 1, i % 4, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, 7 - i, 0);
    // write on the same cycle as done, then done and release together
    for (int i = 0; i < 5; i++) step(0, 1, i, 'h50 + i, 0, 0, 0, 0);
    step(0, 1, 5, 'h55, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 5, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // protocol errors
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 'hDEAD, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    // short tile, then out-of-range address and saturating fill
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, i, 'hC0 + i, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) step(0, 1, i % 16, 'hE0 + i, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    // both banks full mid-read, then reset
    for (int i = 0; i < 3; i++) step(0, 1, i, 'hF0 + i, 0, 1, i, 0);
    step(0, 0, 0, 0, 1, 1, 2, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
           $urandom_range(0, 65535), $urandom_range(0, 6) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 15), $urandom_range(0, 6) == 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
